// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit
// Pipelined control unit for the RISC-V core. It decodes the instruction in
// decode into the control bundle, then carries {valid, bundle, rd} through
// NSTAGE stage registers so that each datapath stage sees the controls of its
// own instruction. It also resolves branch/jump redirect and the load-use
// interlock, and returns pc_sel, flush and stall to fetch/decode.
//
// Parameters
//   NSTAGE     stage registers after decode (legal 2..4); stage 0 is EX,
//              stage NSTAGE-1 is writeback
//   MEM_IDX    stage index that presents the data-memory write (1..NSTAGE-1)
//   LU_WINDOW  stages, starting at EX, whose loads interlock a dependent
//              instruction in decode; 0 disables the interlock
//
// Ports
//   clk, rst           clock and synchronous active-high reset
//   inst, inst_valid   instruction in decode and its valid flag
//   br_cond            branch comparator result for the instruction in EX
//   stall_ext          freezes every stage register (memory wait)
//   ex_*               operand selects, immediate type and branch/jump flags
//                      of the EX stage
//   mem_dm_wr          data-memory write enable at stage MEM_IDX
//   wb_*               register write enable, writeback muxes and destination
//   pc_sel             0 = take redirect target, 1 = PC+4
//   flush              kill the instruction in decode
//   stall              hold PC and the decode register
module pipe_ctrl_unit #(
    parameter int NSTAGE    = 2,
    parameter int MEM_IDX   = 1,
    parameter int LU_WINDOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        inst_valid,
    input  logic        br_cond,
    input  logic        stall_ext,
    output logic        ex_rb1_sel,
    output logic        ex_rb2_sel,
    output logic [2:0]  ex_sign_sel,
    output logic        ex_br1,
    output logic        ex_br2,
    output logic        mem_dm_wr,
    output logic        wb_rb_wr,
    output logic        wb_dm_sel,
    output logic        wb_dm_pc_sel,
    output logic [4:0]  wb_rd,
    output logic        pc_sel,
    output logic        flush,
    output logic        stall
);

    localparam int WB_IDX = NSTAGE - 1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       rb1Sel;
        logic       rb2Sel;
        logic [2:0] signSel;
        logic       br1;
        logic       br2;
        logic       dmWr;
        logic       rbWr;
        logic       dmSel;
        logic       dmPcSel;
        logic [4:0] rd;
    } ctrl_t;

    // Bubbles and reset stages carry this bundle so the select outputs sit at
    // their idle values whenever no real instruction occupies a stage.
    localparam ctrl_t CTRL_RESET = '{rb1Sel: 1'b0, rb2Sel: 1'b0, signSel: 3'd0,
                                     br1: 1'b0, br2: 1'b0, dmWr: 1'b0,
                                     rbWr: 1'b0, dmSel: 1'b1, dmPcSel: 1'b1,
                                     rd: 5'd0};

    logic [6:0]               opcode;
    logic [1:0]               funct3Lo;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    ctrl_t                    decoded;
    logic                     usesRs1;
    logic                     usesRs2;
    logic [NSTAGE-1:0]        valid_q;
    logic [NSTAGE-1:0]        valid_d;
    ctrl_t [NSTAGE-1:0]       stage_q;
    ctrl_t [NSTAGE-1:0]       stage_d;
    logic [NSTAGE-1:0]        luHit;
    logic                     loadUse;
    logic                     redirect;
    logic                     stage0Valid;
    ctrl_t                    stage0Bundle;
    logic                     unusedBits;

    assign opcode   = inst[6:0];
    assign funct3Lo = inst[13:12];
    assign rs1      = inst[19:15];
    assign rs2      = inst[24:20];

    // Instruction decode. Unknown opcodes keep the idle bundle, so they
    // travel down the pipe without enabling anything.
    always_comb begin
        decoded    = CTRL_RESET;
        decoded.rd = inst[11:7];
        usesRs1    = 1'b0;
        usesRs2    = 1'b0;
        case (opcode)
            OP_R: begin
                decoded.rb1Sel = 1'b1;
                decoded.rb2Sel = 1'b1;
                decoded.rbWr   = 1'b1;
                usesRs1        = 1'b1;
                usesRs2        = 1'b1;
            end
            OP_I: begin
                decoded.rb1Sel  = 1'b1;
                decoded.rbWr    = 1'b1;
                decoded.signSel = (funct3Lo == 2'b01) ? 3'd4 : 3'd0;
                usesRs1         = 1'b1;
            end
            OP_LOAD: begin
                decoded.rb1Sel = 1'b1;
                decoded.rbWr   = 1'b1;
                decoded.dmSel  = 1'b0;
                usesRs1        = 1'b1;
            end
            OP_STORE: begin
                decoded.rb1Sel  = 1'b1;
                decoded.signSel = 3'd7;
                decoded.dmWr    = 1'b1;
                usesRs1         = 1'b1;
                usesRs2         = 1'b1;
            end
            OP_BRANCH: begin
                decoded.signSel = 3'd3;
                decoded.br1     = 1'b1;
                usesRs1         = 1'b1;
                usesRs2         = 1'b1;
            end
            OP_JAL: begin
                decoded.signSel = 3'd2;
                decoded.br2     = 1'b1;
                decoded.rbWr    = 1'b1;
                decoded.dmPcSel = 1'b0;
            end
            OP_JALR: begin
                decoded.rb1Sel  = 1'b1;
                decoded.br2     = 1'b1;
                decoded.rbWr    = 1'b1;
                decoded.dmPcSel = 1'b0;
                usesRs1         = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                decoded.signSel = 3'd1;
                decoded.rbWr    = 1'b1;
            end
            default: begin
                decoded = CTRL_RESET;
            end
        endcase
    end

    // A load (the only instruction with dmSel=0) in an interlock-window stage
    // whose non-zero rd feeds a source register of the decode instruction.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_lu
        if (k < LU_WINDOW) begin : g_win
            assign luHit[k] = valid_q[k] & ~stage_q[k].dmSel
                            & (stage_q[k].rd != 5'd0)
                            & ((usesRs1 & (rs1 == stage_q[k].rd))
                             | (usesRs2 & (rs2 == stage_q[k].rd)));
        end else begin : g_nowin
            assign luHit[k] = 1'b0;
        end
    end

    assign loadUse  = inst_valid & (|luHit);
    assign redirect = valid_q[0] & (stage_q[0].br2 | (stage_q[0].br1 & br_cond));

    // Redirect outranks load-use: the decode instruction is on the wrong path,
    // so it becomes a bubble and there is nothing left to stall for.
    assign pc_sel = ~redirect;
    assign flush  = redirect & ~stall_ext;
    assign stall  = stall_ext | (loadUse & ~redirect);

    assign stage0Valid  = inst_valid & ~redirect & ~loadUse;
    assign stage0Bundle = stage0Valid ? decoded : CTRL_RESET;
    assign valid_d      = {valid_q[NSTAGE-2:0], stage0Valid};
    assign stage_d      = {stage_q[NSTAGE-2:0], stage0Bundle};

    // Stage registers: reset clears everything, stall_ext freezes every
    // stage, otherwise the pipe shifts by one with decode entering stage 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            stage_q <= {NSTAGE{CTRL_RESET}};
        end else if (!stall_ext) begin
            valid_q <= valid_d;
            stage_q <= stage_d;
        end
    end

    assign ex_rb1_sel   = stage_q[0].rb1Sel;
    assign ex_rb2_sel   = stage_q[0].rb2Sel;
    assign ex_sign_sel  = stage_q[0].signSel;
    assign ex_br1       = valid_q[0] & stage_q[0].br1;
    assign ex_br2       = valid_q[0] & stage_q[0].br2;
    assign mem_dm_wr    = valid_q[MEM_IDX] & stage_q[MEM_IDX].dmWr;
    assign wb_rb_wr     = valid_q[WB_IDX] & stage_q[WB_IDX].rbWr;
    assign wb_dm_sel    = stage_q[WB_IDX].dmSel;
    assign wb_dm_pc_sel = stage_q[WB_IDX].dmPcSel;
    assign wb_rd        = stage_q[WB_IDX].rd;

    // Immediate fields and the EX-only controls of the last stage are
    // deliberately left unread.
    assign unusedBits = ^{inst[31:25], inst[14], stage_q[WB_IDX]};

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit
// Directed bench for pipe_ctrl_unit. Instance A uses the default 3-stage
// configuration, instance B the 5-stage one (NSTAGE=4, MEM_IDX=2,
// LU_WINDOW=2); both see the same inputs and one of them is checked at a time.
// Every driven cycle pushes the expected bundle of the instruction entering
// EX onto a queue; queue slot k is then the expectation for stage k.
module tb_pipe_ctrl_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic        inst_valid;
    logic        br_cond;
    logic        stall_ext;

    typedef struct packed {
        logic       rb1;
        logic       rb2;
        logic [2:0] sign;
        logic       br1;
        logic       br2;
        logic       memWr;
        logic       wbRbWr;
        logic       wbDmSel;
        logic       wbDmPcSel;
        logic [4:0] wbRd;
        logic       pcSel;
        logic       flush;
        logic       stall;
    } obs_t;

    typedef struct packed {
        logic       v;
        logic       rb1;
        logic       rb2;
        logic [2:0] sign;
        logic       br1;
        logic       br2;
        logic       dmWr;
        logic       rbWr;
        logic       dmSel;
        logic       dmPcSel;
        logic [4:0] rd;
    } exp_t;

    function automatic exp_t rec(input logic rb1, input logic rb2, input logic [2:0] sign,
                                 input logic br1, input logic br2, input logic dmWr,
                                 input logic rbWr, input logic dmSel, input logic dmPcSel,
                                 input logic [4:0] rd);
        return {1'b1, rb1, rb2, sign, br1, br2, dmWr, rbWr, dmSel, dmPcSel, rd};
    endfunction

    localparam exp_t E_BUB = {1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0};

    localparam logic [31:0] I_ADD3  = 32'h002081B3;
    localparam logic [31:0] I_ADD7  = 32'h002083B3;
    localparam logic [31:0] I_ADD6  = 32'h00228333;
    localparam logic [31:0] I_ADD6Z = 32'h00200333;
    localparam logic [31:0] I_ADDI1 = 32'h00500093;
    localparam logic [31:0] I_SLLI8 = 32'h00209413;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_LUI4  = 32'h12345237;
    localparam logic [31:0] I_BEQ   = 32'h00208463;
    localparam logic [31:0] I_LW5   = 32'h0000A283;
    localparam logic [31:0] I_LW0   = 32'h0000A003;
    localparam logic [31:0] I_JAL1  = 32'h010000EF;
    localparam logic [31:0] I_UNK   = 32'h0000007F;

    localparam exp_t E_ADD3  = rec(1, 1, 3'd0, 0, 0, 0, 1, 1, 1, 5'd3);
    localparam exp_t E_ADD7  = rec(1, 1, 3'd0, 0, 0, 0, 1, 1, 1, 5'd7);
    localparam exp_t E_ADD6  = rec(1, 1, 3'd0, 0, 0, 0, 1, 1, 1, 5'd6);
    localparam exp_t E_ADDI1 = rec(1, 0, 3'd0, 0, 0, 0, 1, 1, 1, 5'd1);
    localparam exp_t E_SLLI8 = rec(1, 0, 3'd4, 0, 0, 0, 1, 1, 1, 5'd8);
    localparam exp_t E_SW    = rec(1, 0, 3'd7, 0, 0, 1, 0, 1, 1, 5'd0);
    localparam exp_t E_LUI4  = rec(0, 0, 3'd1, 0, 0, 0, 1, 1, 1, 5'd4);
    localparam exp_t E_BEQ   = rec(0, 0, 3'd3, 1, 0, 0, 0, 1, 1, 5'd8);
    localparam exp_t E_LW5   = rec(1, 0, 3'd0, 0, 0, 0, 1, 0, 1, 5'd5);
    localparam exp_t E_LW0   = rec(1, 0, 3'd0, 0, 0, 0, 1, 0, 1, 5'd0);
    localparam exp_t E_JAL1  = rec(0, 0, 3'd2, 0, 1, 0, 1, 1, 0, 5'd1);
    localparam exp_t E_UNK   = rec(0, 0, 3'd0, 0, 0, 0, 0, 1, 1, 5'd0);

    logic       aRb1, aRb2, aBr1, aBr2, aMemWr, aWbRbWr, aWbDmSel, aWbDmPcSel, aPcSel, aFlush, aStall;
    logic [2:0] aSign;
    logic [4:0] aWbRd;
    logic       bRb1, bRb2, bBr1, bBr2, bMemWr, bWbRbWr, bWbDmSel, bWbDmPcSel, bPcSel, bFlush, bStall;
    logic [2:0] bSign;
    logic [4:0] bWbRd;
    obs_t       obsA;
    obs_t       obsB;

    exp_t pipeQ[$];
    exp_t dropped;
    int   compared   = 0;
    int   mismatched = 0;
    bit   useB       = 1'b0;
    int   nsCur      = 2;
    int   memCur     = 1;

    // Free-running clock
    always #5 clk = ~clk;

    pipe_ctrl_unit #(.NSTAGE(2), .MEM_IDX(1), .LU_WINDOW(1)) dutA (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .br_cond(br_cond), .stall_ext(stall_ext),
        .ex_rb1_sel(aRb1), .ex_rb2_sel(aRb2), .ex_sign_sel(aSign),
        .ex_br1(aBr1), .ex_br2(aBr2), .mem_dm_wr(aMemWr), .wb_rb_wr(aWbRbWr),
        .wb_dm_sel(aWbDmSel), .wb_dm_pc_sel(aWbDmPcSel), .wb_rd(aWbRd),
        .pc_sel(aPcSel), .flush(aFlush), .stall(aStall)
    );

    pipe_ctrl_unit #(.NSTAGE(4), .MEM_IDX(2), .LU_WINDOW(2)) dutB (
        .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
        .br_cond(br_cond), .stall_ext(stall_ext),
        .ex_rb1_sel(bRb1), .ex_rb2_sel(bRb2), .ex_sign_sel(bSign),
        .ex_br1(bBr1), .ex_br2(bBr2), .mem_dm_wr(bMemWr), .wb_rb_wr(bWbRbWr),
        .wb_dm_sel(bWbDmSel), .wb_dm_pc_sel(bWbDmPcSel), .wb_rd(bWbRd),
        .pc_sel(bPcSel), .flush(bFlush), .stall(bStall)
    );

    assign obsA = {aRb1, aRb2, aSign, aBr1, aBr2, aMemWr, aWbRbWr, aWbDmSel, aWbDmPcSel, aWbRd, aPcSel, aFlush, aStall};
    assign obsB = {bRb1, bRb2, bSign, bBr1, bBr2, bMemWr, bWbRbWr, bWbDmSel, bWbDmPcSel, bWbRd, bPcSel, bFlush, bStall};

    function automatic obs_t curObs();
        return useB ? obsB : obsA;
    endfunction

    task automatic cmp(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Registered outputs against the stage expectations held in the queue
    task automatic checkOutput(input string tag);
        obs_t o;
        exp_t ex;
        exp_t mm;
        exp_t wb;
        o  = curObs();
        ex = pipeQ[0];
        mm = pipeQ[memCur];
        wb = pipeQ[nsCur-1];
        cmp({tag, ".ex_rb1_sel"},   8'(o.rb1),       8'(ex.rb1));
        cmp({tag, ".ex_rb2_sel"},   8'(o.rb2),       8'(ex.rb2));
        cmp({tag, ".ex_sign_sel"},  8'(o.sign),      8'(ex.sign));
        cmp({tag, ".ex_br1"},       8'(o.br1),       8'(ex.v & ex.br1));
        cmp({tag, ".ex_br2"},       8'(o.br2),       8'(ex.v & ex.br2));
        cmp({tag, ".mem_dm_wr"},    8'(o.memWr),     8'(mm.v & mm.dmWr));
        cmp({tag, ".wb_rb_wr"},     8'(o.wbRbWr),    8'(wb.v & wb.rbWr));
        cmp({tag, ".wb_dm_sel"},    8'(o.wbDmSel),   8'(wb.dmSel));
        cmp({tag, ".wb_dm_pc_sel"}, 8'(o.wbDmPcSel), 8'(wb.dmPcSel));
        cmp({tag, ".wb_rd"},        8'(o.wbRd),      8'(wb.rd));
    endtask

    // One decode cycle: drive, check the combinational hazard outputs, record
    // what should enter EX, clock, then check the registered outputs.
    task automatic applyStimulus(input string tag, input logic [31:0] i, input logic iv,
                                 input logic bc, input logic se, input logic accept,
                                 input exp_t r, input logic eStall, input logic eFlush,
                                 input logic ePcSel);
        obs_t o;
        inst       = i;
        inst_valid = iv;
        br_cond    = bc;
        stall_ext  = se;
        #1;
        o = curObs();
        cmp({tag, ".stall"},  8'(o.stall), 8'(eStall));
        cmp({tag, ".flush"},  8'(o.flush), 8'(eFlush));
        cmp({tag, ".pc_sel"}, 8'(o.pcSel), 8'(ePcSel));
        if (!se) begin
            pipeQ.push_front(accept ? r : E_BUB);
            dropped = pipeQ.pop_back();
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    // Two reset cycles with an ADD in decode; everything must read idle.
    task automatic doReset(input string tag);
        obs_t o;
        rst        = 1'b1;
        inst       = I_ADD3;
        inst_valid = 1'b1;
        br_cond    = 1'b0;
        stall_ext  = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            o = curObs();
            cmp({tag, ".ex_br1"},       8'(o.br1),       8'd0);
            cmp({tag, ".ex_br2"},       8'(o.br2),       8'd0);
            cmp({tag, ".ex_sign_sel"},  8'(o.sign),      8'd0);
            cmp({tag, ".ex_rb1_sel"},   8'(o.rb1),       8'd0);
            cmp({tag, ".mem_dm_wr"},    8'(o.memWr),     8'd0);
            cmp({tag, ".wb_rb_wr"},     8'(o.wbRbWr),    8'd0);
            cmp({tag, ".wb_dm_sel"},    8'(o.wbDmSel),   8'd1);
            cmp({tag, ".wb_dm_pc_sel"}, 8'(o.wbDmPcSel), 8'd1);
            cmp({tag, ".wb_rd"},        8'(o.wbRd),      8'd0);
            cmp({tag, ".pc_sel"},       8'(o.pcSel),     8'd1);
            cmp({tag, ".flush"},        8'(o.flush),     8'd0);
            cmp({tag, ".stall"},        8'(o.stall),     8'd0);
        end
        rst = 1'b0;
        pipeQ.delete();
        repeat (nsCur) pipeQ.push_back(E_BUB);
    endtask

    // Directed sequence; arguments after the tag are:
    // inst, inst_valid, br_cond, stall_ext, accepted, bundle, stall, flush, pc_sel
    initial begin
        $display("[TB] 3-stage configuration");
        useB = 1'b0; nsCur = 2; memCur = 1;
        doReset("rst3");
        applyStimulus("add3_first", I_ADD3,  1, 0, 0, 1, E_ADD3,  0, 0, 1);
        applyStimulus("addi",       I_ADDI1, 1, 0, 0, 1, E_ADDI1, 0, 0, 1);
        applyStimulus("sw",         I_SW,    1, 0, 0, 1, E_SW,    0, 0, 1);
        applyStimulus("lui",        I_LUI4,  1, 0, 0, 1, E_LUI4,  0, 0, 1);
        applyStimulus("slli",       I_SLLI8, 1, 0, 0, 1, E_SLLI8, 0, 0, 1);
        applyStimulus("beq_t",      I_BEQ,   1, 0, 0, 1, E_BEQ,   0, 0, 1);
        applyStimulus("taken",      I_ADD7,  1, 1, 0, 0, E_ADD7,  0, 1, 0);
        applyStimulus("after_tkn",  I_ADD7,  1, 1, 0, 1, E_ADD7,  0, 0, 1);
        applyStimulus("beq_nt",     I_BEQ,   1, 0, 0, 1, E_BEQ,   0, 0, 1);
        applyStimulus("not_taken",  I_ADD3,  1, 0, 0, 1, E_ADD3,  0, 0, 1);
        applyStimulus("lw5",        I_LW5,   1, 0, 0, 1, E_LW5,   0, 0, 1);
        applyStimulus("lu_stall",   I_ADD6,  1, 0, 0, 0, E_ADD6,  1, 0, 1);
        applyStimulus("lu_go",      I_ADD6,  1, 0, 0, 1, E_ADD6,  0, 0, 1);
        applyStimulus("lw0",        I_LW0,   1, 0, 0, 1, E_LW0,   0, 0, 1);
        applyStimulus("x0_nostall", I_ADD6Z, 1, 0, 0, 1, E_ADD6,  0, 0, 1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus($sformatf("sext%0d", c), I_ADDI1, 1, 0, 1, 0, E_ADDI1, 1, 0, 1);
        end
        applyStimulus("sext_rel",   I_ADDI1, 1, 0, 0, 1, E_ADDI1, 0, 0, 1);
        applyStimulus("jal",        I_JAL1,  1, 0, 0, 1, E_JAL1,  0, 0, 1);
        applyStimulus("jal_sext",   I_ADD3,  1, 0, 1, 0, E_ADD3,  1, 0, 0);
        applyStimulus("jal_flush",  I_ADD3,  1, 0, 0, 0, E_ADD3,  0, 1, 0);
        applyStimulus("unknown",    I_UNK,   1, 0, 0, 1, E_UNK,   0, 0, 1);
        applyStimulus("invalid",    I_ADD3,  0, 0, 0, 0, E_ADD3,  0, 0, 1);
        applyStimulus("drain",      I_ADD3,  0, 0, 0, 0, E_ADD3,  0, 0, 1);

        $display("[TB] 5-stage configuration");
        useB = 1'b1; nsCur = 4; memCur = 2;
        doReset("rst5");
        applyStimulus("b_lw5",      I_LW5,   1, 0, 0, 1, E_LW5,   0, 0, 1);
        applyStimulus("b_indep",    I_ADD7,  1, 0, 0, 1, E_ADD7,  0, 0, 1);
        applyStimulus("b_dep1",     I_ADD6,  1, 0, 0, 0, E_ADD6,  1, 0, 1);
        applyStimulus("b_dep1_go",  I_ADD6,  1, 0, 0, 1, E_ADD6,  0, 0, 1);
        applyStimulus("b_lw5b",     I_LW5,   1, 0, 0, 1, E_LW5,   0, 0, 1);
        applyStimulus("b_dep2a",    I_ADD6,  1, 0, 0, 0, E_ADD6,  1, 0, 1);
        applyStimulus("b_dep2b",    I_ADD6,  1, 0, 0, 0, E_ADD6,  1, 0, 1);
        applyStimulus("b_dep2_go",  I_ADD6,  1, 0, 0, 1, E_ADD6,  0, 0, 1);
        applyStimulus("b_sw",       I_SW,    1, 0, 0, 1, E_SW,    0, 0, 1);
        applyStimulus("b_lw5c",     I_LW5,   1, 0, 0, 1, E_LW5,   0, 0, 1);
        applyStimulus("b_jal",      I_JAL1,  1, 0, 0, 1, E_JAL1,  0, 0, 1);
        applyStimulus("b_jal_lu",   I_ADD6,  1, 0, 0, 0, E_ADD6,  0, 1, 0);
        applyStimulus("b_after",    I_ADD6,  1, 0, 0, 1, E_ADD6,  0, 0, 1);
        applyStimulus("b_sw2",      I_SW,    1, 0, 0, 1, E_SW,    0, 0, 1);
        applyStimulus("b_add3",     I_ADD3,  1, 0, 0, 1, E_ADD3,  0, 0, 1);
        doReset("rst_mid");
        applyStimulus("b_post",     I_ADDI1, 1, 0, 0, 1, E_ADDI1, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
